// File: rtl/rnbip_pkg.sv
// Shared widths, flag bit positions and writeback buffer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rnbip_pkg;

    localparam int DATA_W = 8;
    localparam int RIDX_W = 3;
    localparam int FLAG_W = 4;

    // Flag array bit order: {OddParity, Positive, Cout, Zero}
    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_S = 2;
    localparam int FLG_P = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu_wb_stage_if.sv
// Execute-side and writeback-side handshake bundle for the ALU writeback stage.
// Latency: n/a (wires only).
// Backpressure: ex_valid/ex_ready towards the ALU, wb_valid/wb_ready towards the register file.
// Ports: ex_* carries the ALU result, flags, destination and write enables;
//        wb_* carries the head writeback entry.
interface alu_wb_stage_if #(
    parameter int DATA_W = rnbip_pkg::DATA_W,
    parameter int RIDX_W = rnbip_pkg::RIDX_W,
    parameter int FLAG_W = rnbip_pkg::FLAG_W
);
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_out;
    logic [FLAG_W-1:0] ex_flags;
    logic [RIDX_W-1:0] ex_rd;
    logic              ex_wr_reg;
    logic              ex_wr_flags;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [RIDX_W-1:0] wb_rd;

    // Environment side: drives the ALU results and the register-file ready.
    modport master (
        output ex_valid, ex_out, ex_flags, ex_rd, ex_wr_reg, ex_wr_flags, wb_ready,
        input  ex_ready, wb_valid, wb_data, wb_rd
    );

    // Stage side.
    modport slave (
        input  ex_valid, ex_out, ex_flags, ex_rd, ex_wr_reg, ex_wr_flags, wb_ready,
        output ex_ready, wb_valid, wb_data, wb_rd
    );
endinterface

// File: rtl/wb_skid_buf.sv
// Two-entry in-order writeback FIFO with registered upstream ready.
// Latency: entry enqueued at edge t is presented on wb_* from t+1.
// Backpressure: ex_ready_o drops the cycle after the buffer fills; head holds while wb_ready_i=0.
// Ports: enq_i/enq_dat_i/enq_rd_i push an entry, wb_ready_i pops the head,
//        head/tail valid+index are exported for hazard decode.
module wb_skid_buf #(
    parameter int DATA_W = rnbip_pkg::DATA_W,
    parameter int RIDX_W = rnbip_pkg::RIDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_i,
    input  logic [DATA_W-1:0] enq_dat_i,
    input  logic [RIDX_W-1:0] enq_rd_i,
    input  logic              wb_ready_i,
    output logic              ex_ready_o,
    output logic              wb_valid_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [RIDX_W-1:0] wb_rd_o,
    output logic              head_vld_o,
    output logic              tail_vld_o,
    output logic [RIDX_W-1:0] head_rd_o,
    output logic [RIDX_W-1:0] tail_rd_o
);
    import rnbip_pkg::*;

    buf_state_e        state_q;
    logic              ex_ready_q;
    logic [DATA_W-1:0] head_dat_q;
    logic [RIDX_W-1:0] head_rd_q;
    logic [DATA_W-1:0] tail_dat_q;
    logic [RIDX_W-1:0] tail_rd_q;
    logic              retire;

    assign retire = (state_q != EMPTY) && wb_ready_i;

    // ex_ready_q is set from the state being entered, so it is low exactly
    // while the buffer holds two entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            ex_ready_q <= 1'b1;
            head_dat_q <= '0;
            head_rd_q  <= '0;
            tail_dat_q <= '0;
            tail_rd_q  <= '0;
        end else begin
            ex_ready_q <= 1'b1;
            case (state_q)
                EMPTY: begin
                    if (enq_i) begin
                        head_dat_q <= enq_dat_i;
                        head_rd_q  <= enq_rd_i;
                        state_q    <= ONE;
                    end
                end
                ONE: begin
                    if (enq_i && retire) begin
                        // Head leaves and the new entry takes its place.
                        head_dat_q <= enq_dat_i;
                        head_rd_q  <= enq_rd_i;
                    end else if (enq_i) begin
                        tail_dat_q <= enq_dat_i;
                        tail_rd_q  <= enq_rd_i;
                        state_q    <= TWO;
                        ex_ready_q <= 1'b0;
                    end else if (retire) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    // No enqueue can arrive here: ex_ready was low.
                    if (retire) begin
                        head_dat_q <= tail_dat_q;
                        head_rd_q  <= tail_rd_q;
                        state_q    <= ONE;
                    end else begin
                        ex_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    assign ex_ready_o = ex_ready_q;
    assign wb_valid_o = (state_q != EMPTY);
    assign wb_data_o  = head_dat_q;
    assign wb_rd_o    = head_rd_q;
    assign head_vld_o = (state_q != EMPTY);
    assign tail_vld_o = (state_q == TWO);
    assign head_rd_o  = head_rd_q;
    assign tail_rd_o  = tail_rd_q;

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: flag register, carry feedback, buffered register writes, pending-write mask.
// Latency: accepted result on wb_* and accepted flags on flag_reg one cycle after the accepting edge.
// Backpressure: absorbs two stalled writes, then ex_ready falls until the register file drains one.
// Ports: clk/rst; bus (slave modport) carries ex_* and wb_*; flag_reg, cin_out, rd_busy are status outputs.
module alu_wb_stage #(
    parameter int DATA_W = rnbip_pkg::DATA_W,
    parameter int RIDX_W = rnbip_pkg::RIDX_W,
    parameter int FLAG_W = rnbip_pkg::FLAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_wb_stage_if.slave        bus,
    output logic [FLAG_W-1:0]    flag_reg,
    output logic                 cin_out,
    output logic [2**RIDX_W-1:0] rd_busy
);
    import rnbip_pkg::*;

    logic                 ex_ready;
    logic                 accept;
    logic                 enq;
    logic [FLAG_W-1:0]    flag_d;
    logic [FLAG_W-1:0]    flag_q;
    logic                 head_vld;
    logic                 tail_vld;
    logic [RIDX_W-1:0]    head_rd;
    logic [RIDX_W-1:0]    tail_rd;
    logic [2**RIDX_W-1:0] rd_busy_c;

    assign accept = bus.ex_valid && ex_ready;
    // Flag-only operations are accepted but never occupy a buffer slot.
    assign enq    = accept && bus.ex_wr_reg;

    wb_skid_buf #(
        .DATA_W(DATA_W),
        .RIDX_W(RIDX_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .enq_i      (enq),
        .enq_dat_i  (bus.ex_out),
        .enq_rd_i   (bus.ex_rd),
        .wb_ready_i (bus.wb_ready),
        .ex_ready_o (ex_ready),
        .wb_valid_o (bus.wb_valid),
        .wb_data_o  (bus.wb_data),
        .wb_rd_o    (bus.wb_rd),
        .head_vld_o (head_vld),
        .tail_vld_o (tail_vld),
        .head_rd_o  (head_rd),
        .tail_rd_o  (tail_rd)
    );

    assign bus.ex_ready = ex_ready;

    always_comb begin
        flag_d = flag_q;
        if (accept && bus.ex_wr_flags) begin
            flag_d = bus.ex_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag_reg = flag_q;
    assign cin_out  = flag_q[FLG_C];

    // Both entries may name the same register; OR-ing keeps the bit set
    // until the last pending write to it has retired.
    always_comb begin
        rd_busy_c = '0;
        if (head_vld) begin
            rd_busy_c[head_rd] = 1'b1;
        end
        if (tail_vld) begin
            rd_busy_c[tail_rd] = 1'b1;
        end
    end

    assign rd_busy = rd_busy_c;

endmodule
